// File: rtl/display_scan_capture.sv
// Receiver for the multiplexed 4-digit display bus: debounces each strobe/segment
// pattern, decodes 7-segment codes to BCD and publishes complete 4-digit frames.
module display_scan_capture #(
  parameter int unsigned SETTLE         = 2,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        D1,
  input  logic        D2,
  input  logic        D3,
  input  logic        D4,
  input  logic [6:0]  seg,
  output logic [15:0] digits,
  output logic        frame_valid,
  output logic        seg_err,
  output logic        sel_err
);

  localparam logic [3:0] SETTLE_C  = 4'(SETTLE);
  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);
  localparam logic [6:0] SEG_XOR   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  // Returns {valid, bcd}; bit0 of code is segment a.
  function automatic logic [4:0] seg_decode(input logic [6:0] code);
    logic [4:0] r;
    case (code)
      7'h3F:   r = 5'h10;
      7'h06:   r = 5'h11;
      7'h5B:   r = 5'h12;
      7'h4F:   r = 5'h13;
      7'h66:   r = 5'h14;
      7'h6D:   r = 5'h15;
      7'h7D:   r = 5'h16;
      7'h07:   r = 5'h17;
      7'h7F:   r = 5'h18;
      7'h6F:   r = 5'h19;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  logic [10:0] pat_d, pat_q;
  logic [3:0]  cnt_d, cnt_q;
  logic [3:0]  seen_d, seen_q;
  logic [15:0] shadow_d, shadow_q;
  logic [15:0] digits_d, digits_q;
  logic        fv_d, fv_q;
  logic        seg_pend_d, seg_pend_q;
  logic        sel_pend_d, sel_pend_q;
  logic        seg_err_d, seg_err_q;
  logic        sel_err_d, sel_err_q;
  logic        stable_s;
  logic        sample_s;
  logic [3:0]  strb_s;
  logic [4:0]  dec_s;

  // Next-state logic: settle counter, strobe classification, decode and frame assembly.
  always_comb begin
    pat_d      = {D1, D2, D3, D4, seg ^ SEG_XOR};
    stable_s   = (pat_d == pat_q);
    // Fires only on the transition into SETTLE, so a held pattern is sampled once.
    sample_s   = stable_s && (cnt_q == SETTLE_M1);
    strb_s     = pat_q[10:7];
    dec_s      = seg_decode(pat_q[6:0]);
    cnt_d      = cnt_q;
    seen_d     = seen_q;
    shadow_d   = shadow_q;
    digits_d   = digits_q;
    fv_d       = 1'b0;
    seg_pend_d = 1'b0;
    sel_pend_d = 1'b0;
    seg_err_d  = seg_pend_q;
    sel_err_d  = sel_pend_q;

    if (!stable_s) begin
      cnt_d = 4'd0;
    end else if (cnt_q != SETTLE_C) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d = cnt_q;
    end

    if (seen_q == 4'b1111) begin
      digits_d = shadow_q;
      fv_d     = 1'b1;
      seen_d   = 4'b0000;
    end else begin
      digits_d = digits_q;
    end

    if (sample_s) begin
      case (strb_s)
        4'b0000: begin
          seen_d = seen_d;
        end
        4'b1000, 4'b0100, 4'b0010, 4'b0001: begin
          if (dec_s[4]) begin
            for (int i = 0; i < 4; i++) begin
              if (strb_s[i]) begin
                shadow_d[i*4 +: 4] = dec_s[3:0];
                seen_d[i]          = 1'b1;
              end else begin
                seen_d[i] = seen_d[i];
              end
            end
          end else begin
            seg_pend_d = 1'b1;
          end
        end
        default: begin
          sel_pend_d = 1'b1;
        end
      endcase
    end else begin
      seen_d = seen_d;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q      <= 11'd0;
      cnt_q      <= 4'd0;
      seen_q     <= 4'b0000;
      shadow_q   <= 16'h0000;
      digits_q   <= 16'h0000;
      fv_q       <= 1'b0;
      seg_pend_q <= 1'b0;
      sel_pend_q <= 1'b0;
      seg_err_q  <= 1'b0;
      sel_err_q  <= 1'b0;
    end else begin
      pat_q      <= pat_d;
      cnt_q      <= cnt_d;
      seen_q     <= seen_d;
      shadow_q   <= shadow_d;
      digits_q   <= digits_d;
      fv_q       <= fv_d;
      seg_pend_q <= seg_pend_d;
      sel_pend_q <= sel_pend_d;
      seg_err_q  <= seg_err_d;
      sel_err_q  <= sel_err_d;
    end
  end

  assign digits      = digits_q;
  assign frame_valid = fv_q;
  assign seg_err     = seg_err_q;
  assign sel_err     = sel_err_q;

endmodule

// File: tb/tb_display_scan_capture.sv
// Scoreboard bench: a run-length model of the display bus predicts frames and error
// pulses for an active-high and an active-low instance driven with the same traffic.
module tb_display_scan_capture;

  localparam int SETTLE = 2;

  typedef struct {
    int          cyc;
    int          kind;   // 0 frame, 1 seg_err, 2 sel_err
    logic [15:0] dig;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        d1, d2, d3, d4;
  logic [6:0]  seg_hi;
  logic [6:0]  seg_lo;
  logic [15:0] dig_a, dig_b;
  logic        fv_a, se_a, sl_a, fv_b, se_b, sl_b;

  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  ev_t         exp_q[$];
  logic [15:0] exp_dig = 16'h0000;
  logic [10:0] last_p;
  int          run;
  bit          seen[4];
  logic [3:0]  shadow[4];
  logic [6:0]  codes[10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  assign seg_lo = ~seg_hi;

  display_scan_capture #(.SETTLE(SETTLE), .SEG_ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .reset(reset), .D1(d1), .D2(d2), .D3(d3), .D4(d4), .seg(seg_hi),
    .digits(dig_a), .frame_valid(fv_a), .seg_err(se_a), .sel_err(sl_a));

  display_scan_capture #(.SETTLE(SETTLE), .SEG_ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .reset(reset), .D1(d1), .D2(d2), .D3(d3), .D4(d4), .seg(seg_lo),
    .digits(dig_b), .frame_valid(fv_b), .seg_err(se_b), .sel_err(sl_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic model_clear();
    last_p = 11'd0;
    run    = SETTLE + 1;
    for (int i = 0; i < 4; i++) begin
      seen[i]   = 1'b0;
      shadow[i] = 4'd0;
    end
  endtask

  task automatic push(input int c, input int k, input logic [15:0] d);
    ev_t e;
    e.cyc = c; e.kind = k; e.dig = d;
    exp_q.push_back(e);
  endtask

  // Applies the capture rules to one settled pattern; result appears two cycles later.
  task automatic sample(input logic [10:0] p);
    logic [3:0] strb;
    int k, found;
    strb  = p[10:7];
    k     = 0;
    found = -1;
    if ($countones(strb) == 0) return;
    if ($countones(strb) > 1) begin
      push(cyc + 2, 2, 16'h0000);
      return;
    end
    for (int i = 0; i < 4; i++) if (strb[i]) k = i;
    for (int j = 0; j < 10; j++) if (codes[j] == p[6:0]) found = j;
    if (found < 0) begin
      push(cyc + 2, 1, 16'h0000);
      return;
    end
    shadow[k] = 4'(found);
    seen[k]   = 1'b1;
    if (seen[0] && seen[1] && seen[2] && seen[3]) begin
      push(cyc + 2, 0, {shadow[3], shadow[2], shadow[1], shadow[0]});
      for (int i = 0; i < 4; i++) seen[i] = 1'b0;
    end
  endtask

  task automatic model_step(input logic [10:0] p);
    if (p !== last_p) begin
      last_p = p;
      run    = 1;
    end else begin
      run++;
    end
    if (run == SETTLE + 1) sample(p);
  endtask

  task automatic drive(input logic [3:0] s, input logic [6:0] c, input int h);
    for (int i = 0; i < h; i++) begin
      @(negedge clk);
      {d1, d2, d3, d4} = s;
      seg_hi = c;
      model_step({s, c});
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d events outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    wait_drain(20);
    @(negedge clk);
    reset = 1'b1;
    {d1, d2, d3, d4} = 4'b0000;
    seg_hi = 7'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic check_cycle();
    ev_t        e;
    logic [2:0] efl;
    if (reset) begin
      tests++;
      exp_dig = 16'h0000;
      if ({dig_a, fv_a, se_a, sl_a, dig_b, fv_b, se_b, sl_b} != 38'd0) begin
        fails++;
        $display("FAIL reset_state: got a=%h/%b%b%b b=%h/%b%b%b, expected all zero",
                 dig_a, fv_a, se_a, sl_a, dig_b, fv_b, se_b, sl_b);
      end
      return;
    end
    efl = 3'b000;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      tests++;
      fails++;
      $display("FAIL missed_event: kind %0d due at cycle %0d not seen by cycle %0d", e.kind, e.cyc, cyc);
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      case (e.kind)
        0:       begin efl = 3'b100; exp_dig = e.dig; end
        1:       efl = 3'b010;
        default: efl = 3'b001;
      endcase
    end
    tests++;
    if ({fv_a, se_a, sl_a} !== efl) begin
      fails++;
      $display("FAIL pulses_hi cyc %0d: got fv/seg/sel=%b, expected %b", cyc, {fv_a, se_a, sl_a}, efl);
    end
    tests++;
    if ({fv_b, se_b, sl_b} !== efl) begin
      fails++;
      $display("FAIL pulses_lo cyc %0d: got fv/seg/sel=%b, expected %b", cyc, {fv_b, se_b, sl_b}, efl);
    end
    tests++;
    if (dig_a !== exp_dig) begin
      fails++;
      $display("FAIL digits_hi cyc %0d: got %h, expected %h", cyc, dig_a, exp_dig);
    end
    tests++;
    if (dig_b !== exp_dig) begin
      fails++;
      $display("FAIL digits_lo cyc %0d: got %h, expected %h", cyc, dig_b, exp_dig);
    end
  endtask

  // Monitor: checks both instances one time unit after every rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      check_cycle();
    end
  end

  initial begin
    logic [3:0] s;
    logic [6:0] c;
    reset = 1'b1;
    {d1, d2, d3, d4} = 4'b0000;
    seg_hi = 7'h00;
    model_clear();
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Basic frame 1234.
    drive(4'b1000, 7'h06, 4); drive(4'b0100, 7'h5B, 4);
    drive(4'b0010, 7'h4F, 4); drive(4'b0001, 7'h66, 4);
    drive(4'b0000, 7'h00, 4);
    // One-cycle glitch inside frame 0597.
    drive(4'b1000, 7'h3F, 4); drive(4'b0100, 7'h7F, 1); drive(4'b0100, 7'h6D, 4);
    drive(4'b0010, 7'h6F, 4); drive(4'b0001, 7'h07, 4);
    drive(4'b0000, 7'h00, 4);
    // Undecodable code on D3, then corrected.
    drive(4'b1000, 7'h06, 4); drive(4'b0100, 7'h5B, 4); drive(4'b0010, 7'h00, 4);
    drive(4'b0010, 7'h7D, 4); drive(4'b0001, 7'h66, 4);
    drive(4'b0000, 7'h00, 4);
    // Two strobes together.
    drive(4'b1100, 7'h06, 4);
    drive(4'b0000, 7'h00, 4);
    // Reset mid-frame, then the frame must be rebuilt.
    drive(4'b1000, 7'h7F, 4); drive(4'b0100, 7'h6F, 4);
    do_reset();
    drive(4'b0010, 7'h07, 4); drive(4'b0001, 7'h4F, 4); drive(4'b1000, 7'h5B, 4);
    drive(4'b0100, 7'h66, 4);
    drive(4'b0000, 7'h00, 4);

    // Random traffic, including glitches, idle, multi-strobe and bad codes.
    for (int n = 0; n < 120; n++) begin
      case ($urandom_range(0, 9))
        0:       s = 4'b0000;
        1:       begin
                   s = 4'($urandom_range(3, 15));
                   if ($countones(s) < 2) s = 4'b0011;
                 end
        default: s = 4'b0001 << $urandom_range(0, 3);
      endcase
      if ($urandom_range(0, 4) == 0) c = 7'($urandom);
      else c = codes[$urandom_range(0, 9)];
      drive(s, c, $urandom_range(1, 5));
    end
    drive(4'b0000, 7'h00, SETTLE + 4);
    wait_drain(20);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/display_scan_capture.md
Name: display_scan_capture

Overview:
- Receiving end of the multiplexed 4-digit display bus driven by the display sequencer: active-high digit strobes D1..D4 plus a shared 7-segment code.
- Watches the bus, waits for each strobe/segment pattern to settle, and decodes the segment code back to BCD.
- Assembles a complete 4-digit frame and reports it with a one-cycle frame_valid pulse.
- Used for self-check of the display path and for loop-back testing of the sequencer.

Parameters:
- SETTLE, 2: consecutive cycles a {D1..D4, seg} pattern must stay unchanged before it is sampled; legal range 1..15.
- SEG_ACTIVE_LOW, 0: when 1, seg is inverted at the input register, before decoding.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- D1  input  1  digit-1 strobe (most significant digit).
- D2  input  1  digit-2 strobe.
- D3  input  1  digit-3 strobe.
- D4  input  1  digit-4 strobe (least significant digit).
- seg  input  7  segment code; bit0 = a … bit6 = g; 1 = lit after polarity correction.
- digits  output  16  last complete frame as BCD; D1 digit in [15:12], D4 digit in [3:0].
- frame_valid  output  1  one-cycle pulse; digits was updated on this cycle.
- seg_err  output  1  one-cycle pulse; a settled one-hot pattern carried an undecodable seg value.
- sel_err  output  1  one-cycle pulse; a settled pattern had two or more strobes high.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - reset is asynchronous and active-high.
  - On reset: digits=16'h0000, frame_valid=0, seg_err=0, sel_err=0, input register=0, stability counter=0, seen mask=4'b0000, shadow digits=0.
- Input register:
  - {D1..D4, seg} is registered every cycle, with polarity correction applied.
  - All further logic uses the registered copy only.
- Stability counter:
  - Cleared to 0 whenever the registered pattern differs from its previous value.
  - Otherwise increments, saturating at SETTLE.
  - A sample event happens only on the single cycle the counter reaches SETTLE, so there is at most one sample per dwell.
  - A pattern that holds forever is sampled once.
- Strobe classification at the sample event:
  - All strobes low: idle; no action.
  - Exactly one strobe high: digit sample, handled by the decode rules below.
  - Two or more strobes high: sel_err pulses on the next cycle; mask and shadow are unchanged.
- Decode, hex with bit0=a: 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9.
- Valid code: shadow digit k is overwritten and seen bit k is set.
  - A repeat of digit k within one frame overwrites the shadow value; the latest value wins.
- Any other code: seg_err pulses on the next cycle; shadow k and seen bit k are unchanged.
- Frame completion:
  - On the cycle the seen mask becomes 4'b1111, the next edge copies the shadow digits (including the value just decoded) to digits, pulses frame_valid, and clears the mask.
  - A sample in that same cycle for a new frame cannot occur, because sample events are at least SETTLE+1 cycles apart.
- Latency:
  - A pattern first present at the pins before edge n is registered at edge n.
  - It is sampled at edge n+SETTLE.
  - The resulting frame_valid, seg_err or sel_err is high during the cycle after edge n+SETTLE+1.
  - digits is stable between frame_valid pulses.
- Glitches:
  - Any pattern that holds for fewer than SETTLE+1 registered cycles is ignored and produces no error.
- Reset mid-frame: a partial frame is discarded, and digits returns to 0.
- Error pulses and frame_valid may assert in the same cycle only if both result from the same sample event. This is impossible by construction, so the bench checks that they are mutually exclusive.

Test Plan:
- Reset, then strobe D1..D4 in turn with codes 06,5B,4F,66, each held 4 cycles, SETTLE=2 → exactly one frame_valid pulse, digits=16'h1234, no errors.
- The same sequence with SEG_ACTIVE_LOW=1 and inverted codes (79,24,30,19) → digits=16'h1234.
- D2 held for only 1 cycle with 7F inside an otherwise valid frame 0,5,9,7 (3F,6D,6F,07) → glitch ignored, digits=16'h0597.
- D3 held with seg=7'h00 → seg_err pulse; frame completes only after D3 is re-sent with 7D (digit 6).
- D1 and D2 high together, held 4 cycles → one sel_err pulse, no mask change.
- Assert reset after D1 and D2 have been captured → outputs 0; the frame restarts and needs all four digits before frame_valid.
